seq_divider: RTL and testbench

- Multi-cycle 32-bit integer divider for the processor's execute stage.
- Sits beside the single-cycle ALU and serves DIV/DIVU/REM/REMU.
- Radix-2 restoring algorithm: one quotient bit per clock, start/busy/done handshake.
- Results use the same 32-bit operand width and sign conventions as the ALU datapath; the decoder stalls the pipeline while busy is high.

---
 rtl/seq_divider.sv | 159 +++++++++++++++
 tb/tb_seq_divider.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per clock; start/busy/done handshake with registered results.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Signed,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done,
  output logic             DivByZero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             signed_q, signed_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d, negr_q, negr_d;
  logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic [WIDTH:0]   shifted, diff;

  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    quo_d    = quo_q;
    rmd_d    = rmd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          signed_d = Signed;
          state_d  = PREP;
          dbz_d    = (B == '0);
          // Zero divisor publishes its results at acceptance; PREP only
          // spends the one cycle before the done pulse.
          if (B == '0) begin
            quo_d  = '1;
            rmd_d  = A;
            busy_d = 1'b0;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      PREP: begin
        if (b_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          dvd_d   = (signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
          dvs_d   = (signed_q && b_q[WIDTH-1]) ? -b_q : b_q;
          negq_d  = signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          negr_d  = signed_q & a_q[WIDTH-1];
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        quo_d   = negq_q ? -dvd_q : dvd_q;
        rmd_d   = negr_q ? -rem_q : rem_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      quo_q    <= '0;
      rmd_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      quo_q    <= quo_d;
      rmd_q    <= rmd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Quotient  = quo_q;
  assign Remainder = rmd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic reference model with a cycle-level timing
// model, per-cycle comparison, directed cases and randomized traffic.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst, start, Signed;
  logic [31:0] A, B;
  logic [31:0] Quotient, Remainder;
  logic        busy, done, DivByZero;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Signed(Signed),
    .Quotient(Quotient), .Remainder(Remainder), .busy(busy), .done(done),
    .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    longint na, nb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      if (s) begin
        na = longint'($signed(a));
        nb = longint'($signed(b));
      end else begin
        na = longint'({32'd0, a});
        nb = longint'({32'd0, b});
      end
      lq = na / nb;
      lr = na % nb;
      q = lq[31:0];
      r = lr[31:0];
    end
  endfunction

  // Timing model: cycles remaining until the done pulse after acceptance.
  int          m_cnt = 0;
  logic        m_done = 1'b0, m_busy = 1'b0, m_dbz = 1'b0, was_done;
  logic [31:0] m_q = '0, m_r = '0, p_q, p_r;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_done = 0; m_busy = 0; m_dbz = 0; m_q = '0; m_r = '0;
    end else begin
      was_done = m_done;
      m_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1;
          m_busy = 0;
          if (!m_dbz) begin m_q = p_q; m_r = p_r; end
        end
      end else if (!was_done && start) begin
        ref_div(A, B, Signed, p_q, p_r);
        if (B == 32'd0) begin
          m_q = p_q; m_r = p_r; m_dbz = 1; m_cnt = 1;
        end else begin
          m_dbz = 0; m_busy = 1; m_cnt = 34;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_quotient", Quotient, m_q);
      chk("cyc_remainder", Remainder, m_r);
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("cyc_done", {31'd0, done}, {31'd0, m_done});
      chk("cyc_divbyzero", {31'd0, DivByZero}, {31'd0, m_dbz});
    end
  end

  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] eq, input logic [31:0] er,
                       input logic edbz, input int elat);
    int lat;
    @(negedge clk);
    A = a; B = b; Signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom; Signed = ~s;
    chk({name, "_busy_first"}, {31'd0, busy}, (elat == 1) ? 32'd0 : 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, elat);
    chk({name, "_q"}, Quotient, eq);
    chk({name, "_r"}, Remainder, er);
    chk({name, "_dbz"}, {31'd0, DivByZero}, {31'd0, edbz});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'd0;
      1: pick = 32'hFFFF_FFFF;
      2: pick = 32'h8000_0000;
      3: pick = 32'd1;
      4: pick = $urandom_range(0, 20);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] q, r;
    int lat, ndone;

    // Reference-model pins.
    ref_div(32'd100, 32'd7, 1'b0, q, r);
    chk("model_100_7_q", q, 32'd14);  chk("model_100_7_r", r, 32'd2);
    ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r);
    chk("model_m7_2_q", q, 32'hFFFF_FFFD);  chk("model_m7_2_r", r, 32'hFFFF_FFFF);
    ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r);
    chk("model_ovf_q", q, 32'h8000_0000);  chk("model_ovf_r", r, 32'd0);

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Signed = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_q", Quotient, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    do_op("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 34);
    do_op("s_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34);
    do_op("s_7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 34);
    do_op("dbz_u",    32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1, 1);
    do_op("dbz_s",    32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b1, 1);
    do_op("ovf_s",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 34);
    do_op("ovf_u",    32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0, 34);

    // Start pulses with new operands while busy must be ignored.
    @(negedge clk);
    A = 32'd1000; B = 32'd7; Signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; ndone = 0;
    for (int i = 1; i <= 45; i++) begin
      start = (i == 5 || i == 20);
      A = 32'hDEAD; B = 32'd3;
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          lat = i;
          chk("ignore_q", Quotient, 32'd142);
          chk("ignore_r", Remainder, 32'd6);
        end
      end
    end
    start = 1'b0;
    chk("ignore_latency", lat, 34);
    chk("ignore_done_count", ndone, 1);

    // Reset during RUN aborts the operation.
    @(negedge clk);
    A = 32'h1234_5678; B = 32'd3; Signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_q", Quotient, 32'd0);
    chk("abort_r", Remainder, 32'd0);
    chk("abort_flags", {29'd0, busy, done, DivByZero}, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_op("fresh",    32'hFFFF_FFFF,  32'h10,         1'b0, 32'h0FFF_FFFF,  32'hF,          1'b0, 34);

    // Randomized traffic, including starts while busy or in DONE and rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      A = pick(); B = pick(); Signed = $urandom_range(0, 1);
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
